// File: rtl/shift_unit_if.sv
// rtl/shift_unit_if.sv - request/result handshake bundle for the multi-cycle barrel shifter
//
// Purpose: groups the request side (in_*), the result side (out_*) and the busy
//          flag of shift_unit so the unit and its client share one port.
// Signals:
//   in_valid  / in_ready   request handshake
//   in_data   [WIDTH-1:0]  operand
//   in_shamt  [SHW-1:0]    unsigned shift amount
//   in_op     [1:0]        00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid / out_ready  result handshake
//   out_data  [WIDTH-1:0]  result register
//   busy                   unit is shifting or holding a result
// Modports: slave = the shift unit, master = the client issuing requests.

interface shift_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multi-cycle log-stage barrel shifter (SLL/SRL/SRA/ROL)
//
// Purpose: applies one power-of-two shift stage per clock, MSB stage first,
//          so the per-cycle path is a single stage mux.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-high reset
//   bus     shift_unit_if.slave: in_valid/in_ready/in_data/in_shamt/in_op,
//           out_valid/out_ready/out_data, busy
// Parameters: WIDTH power of two >= 2, SHW with 2**SHW == WIDTH.

module shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic         clock,
    input  logic         reset,
    shift_unit_if.slave  bus
);
    localparam int CW = (SHW > 1) ? $clog2(SHW) : 1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [1:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Every stage result is precomputed with a constant shift; cnt_q only
    // selects among them, keeping the cycle path to one mux level.
    logic [WIDTH-1:0] stage_res [SHW];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int S = 2 ** k;
        // SRA fills from the sign captured at accept rather than the
        // working register's MSB, so the fill is independent of stage order.
        assign stage_res[k] =
            (op_q == OP_SLL) ? (work_q << S) :
            (op_q == OP_SRL) ? (work_q >> S) :
            (op_q == OP_SRA) ? {{S{sign_q}}, work_q[WIDTH-1:S]} :
                               {work_q[WIDTH-1-S:0], work_q[WIDTH-1:WIDTH-S]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            work_q     <= '0;
            out_data_q <= '0;
            shamt_q    <= '0;
            op_q       <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            out_data_q <= out_data_d;
            shamt_q    <= shamt_d;
            op_q       <= op_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        out_data_d = out_data_q;
        shamt_d    = shamt_q;
        op_d       = op_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.in_data;
                    shamt_d = bus.in_shamt;
                    op_d    = bus.in_op;
                    sign_d  = bus.in_data[WIDTH-1];
                    if (bus.in_shamt == '0) begin
                        state_d    = DONE;
                        out_data_d = bus.in_data;
                    end else begin
                        state_d = SHIFT;
                        cnt_d   = CW'(SHW - 1);
                    end
                end
            end
            SHIFT: begin
                // Zero stage bits still spend their cycle so latency is fixed.
                if (shamt_q[cnt_q]) begin
                    work_d = stage_res[cnt_q];
                end
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    out_data_d = work_d;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                // in_ready stays low on the drain edge; the next accept
                // can only happen once IDLE is registered.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = out_data_q;

endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised, multi-cycle barrel shifter for the ALU's shift path. It is the sequential successor to the single-cycle 32-bit logical-left shifter. It supports logical left, logical right, arithmetic right and rotate left at any power-of-two width. The block performs one log2 stage per clock behind a valid/ready handshake on both sides, so its critical path is a single mux level. It sits beside multdiv as a stallable ALU functional unit.

## Interface
- WIDTH, 32: operand and result width. Must be a power of two, ≥ 2.
- SHW, 5: shift-amount width. Must satisfy 2**SHW == WIDTH.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  unsigned shift amount.
- in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result register.
- busy  output  1  high in SHIFT or DONE.

## Operation
- States:
  - IDLE: in_ready = 1.
  - SHIFT: stage counter cnt runs SHW-1 down to 0.
  - DONE: out_valid = 1.
- Accept: in_valid & in_ready at a rising edge.
  - Capture in_data into the working register, plus in_shamt, in_op, and sign = in_data[WIDTH-1].
  - If in_shamt == 0, go to DONE with the data unchanged.
  - Otherwise go to SHIFT with cnt = SHW-1.
- SHIFT, each edge:
  - If shamt[cnt] == 1, shift the working register by 2**cnt per the op. Otherwise hold it.
  - Stages are applied MSB first (16, 8, 4, 2, 1 for WIDTH = 32).
  - If cnt == 0, go to DONE. Else decrement cnt.
- Fill rules:
  - SLL and SRL fill with 0.
  - SRA fills with the captured sign bit.
  - ROL wraps bits shifted out of the MSB into the LSB.
- DONE:
  - out_data is the working register.
  - On out_valid & out_ready at an edge, go to IDLE.
  - out_data keeps its last value in IDLE. Consumers qualify it with out_valid.
- in_valid in SHIFT or DONE is ignored (in_ready = 0). The request is not queued.
- No accept in the cycle a result drains: in_ready rises only after the return to IDLE.
- Result must equal the combinational reference for every op and shamt, 0..WIDTH-1.

## Timing
- Reset values:
  - state IDLE, working register 0, out_data 0, out_valid 0, busy 0, in_ready 1, cnt 0.
  - All registers reset asynchronously.
- Reset mid-operation (SHIFT or DONE): the operation is aborted with no output. The next cycle shows in_ready = 1, out_valid = 0.
- Latency from the accept edge to out_valid high:
  - shamt ≠ 0: SHW edges (5 for WIDTH = 32).
  - shamt == 0: 1 edge.
- Stage bits with value 0 still consume their cycle, so latency is fixed per shamt class.
- out_valid stays high and out_data stays stable until the drain edge, for any length of backpressure.
- Throughput: one operation per SHW+2 cycles maximum (accept, SHW shifts, drain, return to IDLE).
- in_ready, busy and out_valid are decoded from registered state only.

## Test plan
- SLL: in_data 0x0000_0001, shamt 31, out_ready 1 → out_valid exactly 5 cycles after accept, out_data 0x8000_0000; in_ready back high next cycle.
- SRA vs SRL: in_data 0x8000_0000, shamt 4 → SRA 0xF800_0000, SRL 0x0800_0000. Then in_data 0x7FFF_FFFF, SRA shamt 31 → 0x0000_0000.
- ROL: 0x8000_0001, shamt 1 → 0x0000_0003. Also 0x1234_5678, shamt 16 → 0x5678_1234.
- shamt 0 and busy rejection: 0xDEAD_BEEF, shamt 0 → out_valid 1 cycle after accept, data unchanged. A second in_valid held during SHIFT is not accepted (in_ready 0) and is taken only after the drain.
- Backpressure: out_ready low for 10 cycles after out_valid → out_data and out_valid stable throughout, busy 1. Raising out_ready drains on that edge; out_valid 0 next cycle.
- Reset mid-SHIFT: assert reset 2 cycles after accept, deassert → out_valid never rises, in_ready 1, out_data 0. A fresh SLL 0x1, shamt 3 then gives 0x0000_0008. Repeat at WIDTH = 8, SHW = 3: SRA 0x80, shamt 7 → 0xFF.
